// File: rtl/bcd_down_counter.sv
// Multi-digit loadable BCD down counter with per-digit borrow chain and a one-cycle underflow pulse.
// Optional AUTO_RELOAD_EN: underflow restores the last loaded value instead of wrapping to all-9s.

module bcd_digit_dec (
  input  logic [3:0] val,
  input  logic       step,
  input  logic [3:0] raw,
  output logic [3:0] nxt,
  output logic [3:0] clamped,
  output logic       is_zero
);
  always_comb begin
    nxt = val;
    if (step) nxt = (val == 4'd0) ? 4'd9 : val - 4'd1;
  end

  // Load values above 9 saturate so the state can never hold a non-BCD digit
  assign clamped = (raw > 4'd9) ? 4'd9 : raw;
  assign is_zero = (val == 4'd0);
endmodule

module bcd_down_counter #(
  parameter  int N_DIGITS = 2,
  localparam int W        = 4 * N_DIGITS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         zero,
  output logic         borrow
);
  logic [N_DIGITS-1:0][3:0] cur, dec, ld_val, raw;
  logic [N_DIGITS-1:0]      step, dz;
  logic [W-1:0]             all_nine;

  assign cur = q;
  assign raw = d;

  genvar i;
  generate
    for (i = 0; i < N_DIGITS; i++) begin : g_dig
      // Digit i steps only when every lower digit is already 0
      if (i == 0) begin : g_lsd
        assign step[i] = 1'b1;
      end else begin : g_hsd
        assign step[i] = step[i-1] & dz[i-1];
      end
      assign all_nine[4*i +: 4] = 4'd9;
      bcd_digit_dec u_dig (
        .val     (cur[i]),
        .step    (step[i]),
        .raw     (raw[i]),
        .nxt     (dec[i]),
        .clamped (ld_val[i]),
        .is_zero (dz[i])
      );
    end
  endgenerate

  assign zero = &dz;

  logic [W-1:0] wrap_val;
`ifdef AUTO_RELOAD_EN
  logic [W-1:0] reload;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  reload <= '0;
    else if (load) reload <= ld_val;
  end

  assign wrap_val = reload;
`else
  assign wrap_val = all_nine;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q      <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      q      <= ld_val;
      borrow <= 1'b0;
    end else if (en) begin
      q      <= zero ? wrap_val : dec;
      borrow <= zero;
    end else begin
      borrow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter (N_DIGITS=2): directed scenarios plus random traffic vs a decimal model.
// Build with +define+AUTO_RELOAD_EN to check the auto-reload variant.

module tb_bcd_down_counter;
  logic       clk, reset_n, load, en;
  logic [7:0] d, q;
  logic       zero, borrow;

  int total = 0;
  int bad   = 0;

  // Reference state kept as plain decimal integers
  int mval, mreload;
  bit mborrow;

  bcd_down_counter #(.N_DIGITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .d(d), .en(en),
    .q(q), .zero(zero), .borrow(borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int clamp_dec(logic [7:0] v);
    int hi, lo;
    hi = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
    lo = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".q"},      32'(q),      32'(to_bcd(mval)));
    chk({tag, ".zero"},   32'(zero),   32'(mval == 0));
    chk({tag, ".borrow"}, 32'(borrow), 32'(mborrow));
  endtask

  task automatic model(bit l, logic [7:0] dv, bit e);
    if (l) begin
      mval    = clamp_dec(dv);
      mreload = mval;
      mborrow = 1'b0;
    end else if (e) begin
      if (mval == 0) begin
`ifdef AUTO_RELOAD_EN
        mval = mreload;
`else
        mval = 99;
`endif
        mborrow = 1'b1;
      end else begin
        mval    = mval - 1;
        mborrow = 1'b0;
      end
    end else begin
      mborrow = 1'b0;
    end
  endtask

  // Drive, take one edge, then sample 1 time unit later
  task automatic cyc(bit l, logic [7:0] dv, bit e, string tag);
    load = l; d = dv; en = e;
    @(posedge clk);
    #1;
    model(l, dv, e);
    chk_all(tag);
  endtask

  task automatic async_reset(string tag);
    #2 reset_n = 1'b0;
    #1;
    mval = 0; mreload = 0; mborrow = 1'b0;
    chk_all(tag);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; en = 1'b0; d = 8'h00;
    mval = 0; mreload = 0; mborrow = 1'b0;
    #12;
    chk_all("por");
    reset_n = 1'b1;

    // Reset mid-run from 47, no clock edge involved
    cyc(1'b1, 8'h47, 1'b0, "ld47");
    chk("ld47.const", 32'(q), 32'h47);
    async_reset("rst47");
    chk("rst47.const", 32'(q), 32'h00);

    // Cross-digit borrow 20 -> 19
    cyc(1'b1, 8'h21, 1'b0, "ld21");
    cyc(1'b0, 8'h00, 1'b1, "dec20");
    chk("dec20.const", 32'(q), 32'h20);
    cyc(1'b0, 8'h00, 1'b1, "dec19");
    chk("dec19.const", 32'(q), 32'h19);
    cyc(1'b0, 8'h00, 1'b1, "dec18");

    // Underflow
`ifndef AUTO_RELOAD_EN
    cyc(1'b1, 8'h01, 1'b0, "ld01");
    cyc(1'b0, 8'h00, 1'b1, "to00");
    cyc(1'b0, 8'h00, 1'b1, "wrap99");
    chk("wrap99.const", 32'({q, borrow}), 32'({8'h99, 1'b1}));
    cyc(1'b0, 8'h00, 1'b1, "after99");
    chk("after99.const", 32'({q, borrow}), 32'({8'h98, 1'b0}));
`else
    cyc(1'b1, 8'h03, 1'b0, "ld03");
    cyc(1'b0, 8'h00, 1'b1, "ar02");
    cyc(1'b0, 8'h00, 1'b1, "ar01");
    cyc(1'b0, 8'h00, 1'b1, "ar00");
    cyc(1'b0, 8'h00, 1'b1, "ar03");
    chk("ar03.const", 32'({q, borrow}), 32'({8'h03, 1'b1}));
    cyc(1'b0, 8'h00, 1'b0, "arhold");
    async_reset("arrst");
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h00, 1'b1, "ar_noload");
      chk("ar_noload.const", 32'({q, borrow}), 32'({8'h00, 1'b1}));
    end
`endif

    // load beats en; clamp of non-BCD digits
    cyc(1'b1, 8'h55, 1'b1, "ld_en55");
    chk("ld_en55.const", 32'({q, borrow}), 32'({8'h55, 1'b0}));
    cyc(1'b1, 8'hAF, 1'b0, "clampAF");
    chk("clampAF.const", 32'(q), 32'h99);
    cyc(1'b1, 8'h3C, 1'b1, "clamp3C");

    // en toggling from 10
    cyc(1'b1, 8'h10, 1'b0, "ld10");
    cyc(1'b0, 8'h00, 1'b1, "t09");
    cyc(1'b0, 8'h00, 1'b0, "t09hold");
    chk("t09hold.const", 32'({q, borrow}), 32'({8'h09, 1'b0}));
    cyc(1'b0, 8'h00, 1'b1, "t08");

    // Full sweep 99 -> 00 -> underflow
    cyc(1'b1, 8'h99, 1'b0, "ld99");
    for (int k = 0; k < 100; k++) cyc(1'b0, 8'h00, 1'b1, "sweep");

    // Random traffic, with occasional async reset
    for (int k = 0; k < 400; k++) begin
      bit         rl, re;
      logic [7:0] rd;
      rl = ($urandom_range(0, 7) == 0);
      re = ($urandom_range(0, 3) != 0);
      rd = 8'($urandom);
      cyc(rl, rd, re, "rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
